// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
// Both channels are valid/ready: a transfer happens on any rising edge where valid and ready are both high.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, x, y, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    modport slave (
        input  in_valid, x, y, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Add/subtract of two WIDTH-bit operands, DIGIT bits per clock through a ripple slice and a registered carry.
// Result registers only update when the last digit completes, so they never show a partial sum.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    digit_serial_adder_if.slave bus,
    output logic [1:0]          state_dbg
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (DIGIT < 1) begin : g_bad_digit
            $error("digit_serial_adder: DIGIT must be >= 1");
        end else if ((WIDTH % DIGIT) != 0) begin : g_bad_ratio
            $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, y_q, r_q, r_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;
    logic [DIGIT-1:0] xd, yd, sd;
    logic             dc_out, c_msb, last, accept, consume;
    int               base;

    assign accept  = bus.in_valid && (state_q == IDLE);
    assign consume = bus.out_ready && (state_q == DONE);
    assign last    = (cnt_q == CW'(NDIG - 1));

    // Digit slice: operand y is already inverted for subtraction, so this is always an add.
    always_comb begin
        base           = int'(cnt_q) * DIGIT;
        xd             = x_q[base +: DIGIT];
        yd             = y_q[base +: DIGIT];
        {dc_out, sd}   = {1'b0, xd} + {1'b0, yd} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the top bit of this digit, recovered from the sum bit.
        c_msb          = xd[DIGIT-1] ^ yd[DIGIT-1] ^ sd[DIGIT-1];
        r_d            = r_q;
        r_d[base +: DIGIT] = sd;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = RUN;
            RUN:     if (last)    state_d = DONE;
            DONE:    if (consume) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        x_q     <= bus.x;
                        y_q     <= bus.y ^ {WIDTH{bus.sub}};
                        carry_q <= bus.sub | bus.cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    r_q     <= r_d;
                    carry_q <= dc_out;
                    if (last) begin
                        sum_q  <= r_d;
                        cout_q <= dc_out;
                        ovf_q  <= c_msb ^ dc_out;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed vectors and corner sequences on a 16/4 instance,
// then concurrent random sweeps on 16/1, 16/16 and 32/8 instances.
module tb_digit_serial_adder;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    bit   sweep_go = 1'b0;
    logic [1:0] m_state;

    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(16)) m_if ();
    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .reset(reset), .bus(m_if), .state_dbg(m_state)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        cin;
        logic        sub;
        logic [15:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
    } vec_t;

    vec_t        vecs[9];
    logic [17:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic m_send(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s,
                          input bit push, input logic [17:0] e);
        int n;
        m_if.x        = x;
        m_if.y        = y;
        m_if.cin      = c;
        m_if.sub      = s;
        m_if.in_valid = 1'b1;
        n = 0;
        while (!m_if.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", 64'(m_if.in_ready), 64'd1);
        tick();
        m_if.in_valid = 1'b0;
        if (push) exp_q.push_back(e);
    endtask

    task automatic m_wait(output int lat);
        lat = 0;
        while (!m_if.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic m_collect(input string name);
        logic [17:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: result with empty expected queue", name);
        end else begin
            e = exp_q.pop_front();
            check(name, 64'({m_if.overflow, m_if.cout, m_if.sum}), 64'(e));
        end
        m_if.out_ready = 1'b1;
        tick();
        m_if.out_ready = 1'b0;
    endtask

    // Random sweeps on the other parameter points, each with its own scoreboard.
    for (genvar g = 0; g < 3; g++) begin : gen_sweep
        localparam int GW = (g == 2) ? 32 : 16;
        localparam int GD = (g == 0) ? 1 : (g == 1) ? 16 : 8;
        localparam int GN = 30;

        bit               done = 1'b0;
        logic [1:0]       st;
        logic [GW+1:0]    exp_q[$];

        digit_serial_adder_if #(.WIDTH(GW)) s_if ();
        digit_serial_adder #(.WIDTH(GW), .DIGIT(GD)) u_dut (
            .clk(clk), .reset(reset), .bus(s_if), .state_dbg(st)
        );

        function automatic logic [GW+1:0] model(input logic [GW-1:0] a, input logic [GW-1:0] b,
                                                 input logic c, input logic s);
            logic [GW:0] full;
            logic        ov;
            if (s) begin
                full = {1'b0, a} - {1'b0, b};
                ov   = (a[GW-1] != b[GW-1]) && (full[GW-1] != a[GW-1]);
                return {ov, ~full[GW], full[GW-1:0]};
            end
            full = {1'b0, a} + {1'b0, b} + {{GW{1'b0}}, c};
            ov   = (a[GW-1] == b[GW-1]) && (full[GW-1] != a[GW-1]);
            return {ov, full[GW], full[GW-1:0]};
        endfunction

        initial begin : drv
            logic [63:0] ra, rb;
            int k;
            s_if.in_valid = 1'b0;
            s_if.x        = '0;
            s_if.y        = '0;
            s_if.cin      = 1'b0;
            s_if.sub      = 1'b0;
            wait (sweep_go);
            tick();
            for (int n = 0; n < GN; n++) begin
                repeat ($urandom_range(0, 3)) tick();
                ra = {$urandom(), $urandom()};
                rb = {$urandom(), $urandom()};
                s_if.x        = ra[GW-1:0];
                s_if.y        = rb[GW-1:0];
                s_if.cin      = 1'($urandom_range(0, 1));
                s_if.sub      = 1'($urandom_range(0, 1));
                s_if.in_valid = 1'b1;
                k = 0;
                while (!s_if.in_ready && k < 200) begin
                    tick();
                    k++;
                end
                if (!s_if.in_ready) begin
                    total++;
                    bad++;
                    $display("FAIL sweep%0d_accept: in_ready never rose", g);
                end
                tick();
                exp_q.push_back(model(s_if.x, s_if.y, s_if.cin, s_if.sub));
                s_if.in_valid = 1'b0;
            end
        end

        initial begin : mon
            logic [GW+1:0] e;
            int got;
            int cyc;
            s_if.out_ready = 1'b0;
            wait (sweep_go);
            tick();
            got = 0;
            cyc = 0;
            while (got < GN && cyc < 6000) begin
                s_if.out_ready = ($urandom_range(0, 2) != 0);
                if (s_if.out_valid && s_if.out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sweep%0d_extra: result with empty expected queue", g);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("sweep%0d_res%0d", g, got),
                              64'({s_if.overflow, s_if.cout, s_if.sum}), 64'(e));
                    end
                    got++;
                end
                tick();
                cyc++;
            end
            s_if.out_ready = 1'b0;
            check($sformatf("sweep%0d_count", g), 64'(got), 64'(GN));
            repeat (GD == 1 ? 20 : 6) tick();
            check($sformatf("sweep%0d_no_dup", g), 64'(s_if.out_valid), 64'd0);
            check($sformatf("sweep%0d_q_empty", g), 64'(exp_q.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin : main
        int lat;
        int n;
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0};
        vecs[8] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        reset          = 1'b1;
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b0;
        m_if.x         = '0;
        m_if.y         = '0;
        m_if.cin       = 1'b0;
        m_if.sub       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", 64'(m_if.in_ready), 64'd1);
        check("rst_out_valid", 64'(m_if.out_valid), 64'd0);
        check("rst_busy", 64'(m_if.busy), 64'd0);
        check("rst_result", 64'({m_if.overflow, m_if.cout, m_if.sum}), 64'd0);
        check("rst_state", 64'(m_state), 64'd0);

        for (int i = 0; i < 9; i++) begin
            m_send(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub, 1'b1,
                   {vecs[i].e_ovf, vecs[i].e_cout, vecs[i].e_sum});
            check($sformatf("vec%0d_busy", i), 64'(m_if.busy), 64'd1);
            m_wait(lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            m_collect($sformatf("vec%0d", i));
            check($sformatf("vec%0d_released", i), 64'({m_if.in_ready, m_if.out_valid}), 64'b10);
        end

        // Backpressure: result held, new operands ignored while DONE.
        m_send(16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b1, 18'h01000);
        m_wait(lat);
        for (int k = 0; k < 3; k++) begin
            m_if.x        = 16'($urandom());
            m_if.y        = 16'($urandom());
            m_if.in_valid = 1'b1;
            tick();
            check("hold_result", 64'({m_if.overflow, m_if.cout, m_if.sum}), 64'h01000);
            check("hold_flags", 64'({m_if.out_valid, m_if.in_ready}), 64'b10);
        end
        m_if.in_valid = 1'b0;
        m_collect("hold_final");
        check("hold_release", 64'({m_if.in_ready, m_if.out_valid}), 64'b10);
        repeat (6) tick();
        check("hold_not_taken", 64'({m_if.out_valid, m_state}), 64'd0);

        // Reset during the second RUN cycle discards the op and clears the result.
        m_send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 18'h0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_flags", 64'({m_if.in_ready, m_if.out_valid, m_if.busy}), 64'b100);
        check("midrst_result", 64'({m_if.overflow, m_if.cout, m_if.sum}), 64'd0);
        m_send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 18'h00002);
        m_wait(lat);
        check("midrst_latency", 64'(lat), 64'd4);
        m_collect("midrst_next");

        sweep_go = 1'b1;
        n = 0;
        while (!(gen_sweep[0].done && gen_sweep[1].done && gen_sweep[2].done) && n < 20000) begin
            tick();
            n++;
        end
        check("sweep_finished",
              64'({gen_sweep[0].done, gen_sweep[1].done, gen_sweep[2].done}), 64'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
